// File: rtl/acc_cfg_pkg.sv
// rtl/acc_cfg_pkg.sv - shared constants and FSM state type for the accelerator run controller
package acc_cfg_pkg;

  localparam logic [31:0] ADDR_TH     = 32'h0000_0970;
  localparam logic [31:0] ADDR_OP     = 32'h0000_0974;
  localparam logic [31:0] ADDR_START  = 32'h0000_0978;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_097C;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_KNN  = 2'b01;
  localparam logic [1:0] MODE_SVM  = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  localparam logic OP_OR  = 1'b0;
  localparam logic OP_AND = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_RESULT
  } state_t;

endpackage

// File: rtl/acc_done_collector.sv
// rtl/acc_done_collector.sv - sticky engine done/class capture and stress combine
module acc_done_collector
  import acc_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       capture,
  input  logic [1:0] mode,
  input  logic       op,
  input  logic       knn_done,
  input  logic       knn_class,
  input  logic       svm_done,
  input  logic       svm_class,
  output logic       knn_cls,
  output logic       svm_cls,
  output logic       complete,
  output logic       stress
);

  logic knn_got;
  logic svm_got;
  logic knn_now;
  logic svm_now;
  logic knn_eff;
  logic svm_eff;

  // complete and stress include strobes arriving this cycle so RESULT follows the last done directly
  always_comb begin
    knn_now  = capture & mode[0] & knn_done & ~knn_got;
    svm_now  = capture & mode[1] & svm_done & ~svm_got;
    knn_eff  = knn_got ? knn_cls : knn_class;
    svm_eff  = svm_got ? svm_cls : svm_class;
    complete = (~mode[0] | knn_got | knn_now) & (~mode[1] | svm_got | svm_now);
    stress   = 1'b0;
    case (mode)
      MODE_KNN:  stress = knn_eff;
      MODE_SVM:  stress = svm_eff;
      MODE_BOTH: stress = (op == OP_AND) ? (knn_eff & svm_eff) : (knn_eff | svm_eff);
      default:   stress = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      knn_got <= 1'b0;
      svm_got <= 1'b0;
      knn_cls <= 1'b0;
      svm_cls <= 1'b0;
    end else if (clear) begin
      knn_got <= 1'b0;
      svm_got <= 1'b0;
      knn_cls <= 1'b0;
      svm_cls <= 1'b0;
    end else begin
      if (knn_now) begin
        knn_got <= 1'b1;
        knn_cls <= knn_class;
      end
      if (svm_now) begin
        svm_got <= 1'b1;
        svm_cls <= svm_class;
      end
    end
  end

endmodule

// File: rtl/acc_cfg_regfile.sv
// rtl/acc_cfg_regfile.sv - host register slave and KNN/SVM run controller
module acc_cfg_regfile
  import acc_cfg_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              bus_err,
  output logic [15:0]       knn_th,
  output logic [15:0]       svm_th,
  output logic              knn_start,
  output logic              svm_start,
  input  logic              knn_done,
  input  logic              knn_class,
  input  logic              svm_done,
  input  logic              svm_class,
  output logic              valid,
  output logic              stress_out
);

  localparam int CNT_W = $clog2(TIMEOUT);

  state_t             state;
  logic [31:0]        th;
  logic               op;
  logic [1:0]         mode;
  logic               done_flag;
  logic               timeout_flag;
  logic [CNT_W-1:0]   cnt;

  logic               hit_th, hit_op, hit_start, hit_status, mapped;
  logic               idle, busy;
  logic [1:0]         start_mode;
  logic               launch_req, abort_req, th_we, op_we, rd_ok, err;
  logic [7:0]         status_word;
  logic [DATA_W-1:0]  rdata;

  logic               knn_cls, svm_cls, complete, stress;

  assign knn_th = th[15:0];
  assign svm_th = th[31:16];

  always_comb begin
    hit_th      = (address == ADDR_W'(ADDR_TH));
    hit_op      = (address == ADDR_W'(ADDR_OP));
    hit_start   = (address == ADDR_W'(ADDR_START));
    hit_status  = (address == ADDR_W'(ADDR_STATUS));
    mapped      = hit_th | hit_op | hit_start | hit_status;
    idle        = (state == ST_IDLE);
    busy        = ~idle;
    start_mode  = write_data[1:0];
    launch_req  = enable & write & hit_start & (start_mode != MODE_IDLE) & idle;
    abort_req   = enable & write & hit_start & (start_mode == MODE_IDLE) & busy;
    th_we       = enable & write & hit_th & idle;
    op_we       = enable & write & hit_op & idle;
    rd_ok       = enable & ~write & mapped;
    // configuration writes and relaunches are refused while a run is in flight
    err         = enable & (~mapped | (write & hit_status) |
                  (write & busy & (hit_th | hit_op | (hit_start & (start_mode != MODE_IDLE)))));
    status_word = {mode, stress_out, svm_cls, knn_cls, timeout_flag, done_flag, busy};
    rdata       = '0;
    if (hit_th)     rdata = DATA_W'(th);
    if (hit_op)     rdata = DATA_W'(op);
    if (hit_status) rdata = DATA_W'(status_word);
  end

  acc_done_collector u_collector (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (launch_req),
    .capture   ((state == ST_RUN) & ~abort_req),
    .mode      (mode),
    .op        (op),
    .knn_done  (knn_done),
    .knn_class (knn_class),
    .svm_done  (svm_done),
    .svm_class (svm_class),
    .knn_cls   (knn_cls),
    .svm_cls   (svm_cls),
    .complete  (complete),
    .stress    (stress)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      th           <= '0;
      op           <= OP_OR;
      mode         <= MODE_IDLE;
      done_flag    <= 1'b0;
      timeout_flag <= 1'b0;
      cnt          <= '0;
      read_data    <= '0;
      read_valid   <= 1'b0;
      bus_err      <= 1'b0;
      knn_start    <= 1'b0;
      svm_start    <= 1'b0;
      valid        <= 1'b0;
      stress_out   <= 1'b0;
    end else begin
      read_data  <= rd_ok ? rdata : '0;
      read_valid <= rd_ok;
      bus_err    <= err;
      knn_start  <= 1'b0;
      svm_start  <= 1'b0;
      valid      <= 1'b0;
      if (th_we) th <= write_data[31:0];
      if (op_we) op <= write_data[0];
      case (state)
        ST_IDLE: begin
          if (launch_req) begin
            state        <= ST_LAUNCH;
            mode         <= start_mode;
            done_flag    <= 1'b0;
            timeout_flag <= 1'b0;
            knn_start    <= start_mode[0];
            svm_start    <= start_mode[1];
          end
        end
        ST_LAUNCH: begin
          cnt   <= '0;
          state <= abort_req ? ST_IDLE : ST_RUN;
        end
        ST_RUN: begin
          // abort beats a completing strobe; a completion in the final cycle beats timeout
          if (abort_req) begin
            state <= ST_IDLE;
          end else if (complete) begin
            state      <= ST_RESULT;
            valid      <= 1'b1;
            stress_out <= stress;
            done_flag  <= 1'b1;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state        <= ST_IDLE;
            timeout_flag <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_cfg_regfile.sv
// tb/tb_acc_cfg_regfile.sv - randomized and directed bench with a transaction-level reference model
module tb_acc_cfg_regfile;

  localparam int TO = 16;
  localparam logic [31:0] A_TH = 32'h970, A_OP = 32'h974, A_ST = 32'h978, A_SS = 32'h97C;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        write = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic        knn_done = 1'b0, knn_class = 1'b0, svm_done = 1'b0, svm_class = 1'b0;
  logic [31:0] read_data;
  logic        read_valid, bus_err, knn_start, svm_start, valid, stress_out;
  logic [15:0] knn_th, svm_th;

  always #5 clk = ~clk;

  acc_cfg_regfile #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .write(write), .address(address),
    .write_data(write_data), .read_data(read_data), .read_valid(read_valid), .bus_err(bus_err),
    .knn_th(knn_th), .svm_th(svm_th), .knn_start(knn_start), .svm_start(svm_start),
    .knn_done(knn_done), .knn_class(knn_class), .svm_done(svm_done), .svm_class(svm_class),
    .valid(valid), .stress_out(stress_out)
  );

  int n_checks = 0;
  int n_pass = 0;
  int vcount = 0;
  int scount = 0;

  // reference model: register contents, run stage (0 idle, 1 launch, 2 run, 3 result) and run age
  logic [31:0] m_th;
  logic        m_op, m_stress, m_done, m_to, m_kc, m_sc, m_kgot, m_sgot;
  logic [1:0]  m_mode;
  int          m_stage, m_runs;
  logic [31:0] e_rd;
  logic        e_rv, e_err, e_ks, e_ss, e_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] m_status();
    return {24'b0, m_mode, m_stress, m_sc, m_kc, m_to, m_done, (m_stage != 0)};
  endfunction

  task automatic model_reset();
    m_th = '0; m_op = 1'b0; m_stress = 1'b0; m_done = 1'b0; m_to = 1'b0;
    m_kc = 1'b0; m_sc = 1'b0; m_kgot = 1'b0; m_sgot = 1'b0; m_mode = 2'b00;
    m_stage = 0; m_runs = 0;
    e_rd = '0; e_rv = 1'b0; e_err = 1'b0; e_ks = 1'b0; e_ss = 1'b0; e_valid = 1'b0;
  endtask

  task automatic model_step();
    logic busy, launch, abort, mapped;
    logic [1:0] md;
    busy = (m_stage != 0); launch = 1'b0; abort = 1'b0; md = write_data[1:0];
    e_rd = '0; e_rv = 1'b0; e_err = 1'b0; e_ks = 1'b0; e_ss = 1'b0; e_valid = 1'b0;
    if (enable) begin
      mapped = (address == A_TH) || (address == A_OP) || (address == A_ST) || (address == A_SS);
      if (!mapped) e_err = 1'b1;
      else if (!write) begin
        e_rv = 1'b1;
        if (address == A_TH) e_rd = m_th;
        else if (address == A_OP) e_rd = {31'b0, m_op};
        else if (address == A_SS) e_rd = m_status();
      end
      else if (address == A_SS) e_err = 1'b1;
      else if (address == A_ST) begin
        if (md == 2'b00) abort = busy;
        else if (busy) e_err = 1'b1;
        else launch = 1'b1;
      end
      else if (busy) e_err = 1'b1;
      else if (address == A_TH) m_th = write_data;
      else m_op = write_data[0];
    end
    case (m_stage)
      0: if (launch) begin
        m_stage = 1; m_mode = md; m_done = 1'b0; m_to = 1'b0;
        m_kgot = 1'b0; m_sgot = 1'b0; m_kc = 1'b0; m_sc = 1'b0;
        e_ks = md[0]; e_ss = md[1];
      end
      1: if (abort) m_stage = 0; else begin m_stage = 2; m_runs = 0; end
      2: if (abort) m_stage = 0;
         else begin
           if (m_mode[0] && knn_done && !m_kgot) begin m_kgot = 1'b1; m_kc = knn_class; end
           if (m_mode[1] && svm_done && !m_sgot) begin m_sgot = 1'b1; m_sc = svm_class; end
           if ((!m_mode[0] || m_kgot) && (!m_mode[1] || m_sgot)) begin
             m_stage = 3; e_valid = 1'b1; m_done = 1'b1;
             if (m_mode == 2'b01) m_stress = m_kc;
             else if (m_mode == 2'b10) m_stress = m_sc;
             else m_stress = m_op ? (m_kc & m_sc) : (m_kc | m_sc);
           end else begin
             m_runs++;
             if (m_runs == TO) begin m_stage = 0; m_to = 1'b1; end
           end
         end
      default: m_stage = 0;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!resetn) model_reset();
      chk("read_data", read_data, e_rd);
      chk("read_valid", 32'(read_valid), 32'(e_rv));
      chk("bus_err", 32'(bus_err), 32'(e_err));
      chk("knn_start", 32'(knn_start), 32'(e_ks));
      chk("svm_start", 32'(svm_start), 32'(e_ss));
      chk("valid", 32'(valid), 32'(e_valid));
      chk("stress_out", 32'(stress_out), 32'(m_stress));
      chk("knn_th", 32'(knn_th), 32'(m_th[15:0]));
      chk("svm_th", 32'(svm_th), 32'(m_th[31:16]));
      if (valid) vcount++;
      if (svm_start) scount++;
      if (resetn) model_step();
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    enable = 1'b1; write = 1'b1; address = a; write_data = d;
    cycle();
    enable = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    enable = 1'b1; write = 1'b0; address = a;
    cycle();
    enable = 1'b0;
  endtask

  task automatic done_pulse(input logic k, input logic kc, input logic s, input logic sc);
    knn_done = k; knn_class = kc; svm_done = s; svm_class = sc;
    cycle();
    knn_done = 1'b0; svm_done = 1'b0;
  endtask

  logic [31:0] bad_addr [4] = '{32'h980, 32'h971, 32'h96C, 32'h1970};

  initial begin
    int v0, s0, pd;
    repeat (3) cycle();
    resetn = 1'b1;
    cycle();

    rd(A_TH);  chk("rst_th_rv", 32'(read_valid), 32'd1); chk("rst_th_rd", read_data, 32'h0);
    rd(A_OP);  chk("rst_op_rd", read_data, 32'h0);
    rd(A_SS);  chk("rst_status_rd", read_data, 32'h0);
    cycle();   chk("rd_pulse_drop", 32'(read_valid), 32'd0);
    wr(A_TH, 32'h1812_3456);
    chk("th_knn", 32'(knn_th), 32'h3456); chk("th_svm", 32'(svm_th), 32'h1812);
    rd(A_TH);  chk("th_readback", read_data, 32'h1812_3456);

    wr(A_OP, 32'h0);
    v0 = vcount;
    wr(A_ST, 32'h3);
    repeat (3) cycle();
    done_pulse(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle();
    done_pulse(1'b0, 1'b0, 1'b1, 1'b1);
    chk("or_valid", 32'(valid), 32'd1); chk("or_stress", 32'(stress_out), 32'd1);
    repeat (2) cycle();
    chk("or_valid_count", 32'(vcount - v0), 32'd1);
    chk("model_status_or", m_status(), 32'hF2);
    rd(A_SS);  chk("or_status", read_data, 32'hF2);

    wr(A_OP, 32'h1);
    wr(A_ST, 32'h3);
    cycle(); cycle();
    done_pulse(1'b1, 1'b1, 1'b1, 1'b0);
    chk("and_valid", 32'(valid), 32'd1); chk("and_stress", 32'(stress_out), 32'd0);
    cycle();   chk("and_valid_drop", 32'(valid), 32'd0);

    s0 = scount;
    wr(A_ST, 32'h1);
    chk("knn_only_kstart", 32'(knn_start), 32'd1); chk("knn_only_sstart", 32'(svm_start), 32'd0);
    cycle();
    done_pulse(1'b0, 1'b0, 1'b1, 1'b1);
    wr(A_TH, 32'hDEAD_BEEF);
    chk("th_busy_err", 32'(bus_err), 32'd1); chk("th_busy_keep", 32'(knn_th), 32'h3456);
    done_pulse(1'b1, 1'b1, 1'b0, 1'b0);
    chk("knn_only_valid", 32'(valid), 32'd1); chk("knn_only_stress", 32'(stress_out), 32'd1);
    repeat (2) cycle();
    chk("knn_only_no_sstart", 32'(scount - s0), 32'd0);
    rd(A_SS);  chk("knn_only_status", read_data, 32'h6A);

    v0 = vcount;
    wr(A_ST, 32'h2);
    repeat (16) cycle();
    rd(A_SS);  chk("to_last_run", read_data, 32'hA1);
    rd(A_SS);  chk("to_status", read_data, 32'hA4);
    chk("to_no_valid", 32'(vcount - v0), 32'd0);
    wr(A_ST, 32'h2);
    rd(A_SS);  chk("to_cleared", read_data, 32'hA1);
    wr(A_ST, 32'h0); chk("abort_no_err", 32'(bus_err), 32'd0);
    cycle();
    rd(A_SS);  chk("abort_idle", read_data, 32'hA0);

    rd(32'h980); chk("unmapped_err", 32'(bus_err), 32'd1); chk("unmapped_rv", 32'(read_valid), 32'd0);
    v0 = vcount;
    wr(A_ST, 32'h3);
    repeat (3) cycle();
    wr(A_ST, 32'h0);
    repeat (3) cycle();
    chk("abort_no_valid", 32'(vcount - v0), 32'd0);
    rd(A_SS);  chk("abort_status", read_data, 32'hE0);

    wr(A_ST, 32'h3);
    repeat (4) cycle();
    #2 resetn = 1'b0;
    #1;
    chk("arst_th", {svm_th, knn_th}, 32'h0); chk("arst_stress", 32'(stress_out), 32'd0);
    chk("arst_misc", {26'b0, read_valid, bus_err, knn_start, svm_start, valid, 1'b0}, 32'h0);
    chk("arst_rd", read_data, 32'h0);
    repeat (2) cycle();
    resetn = 1'b1;
    cycle();
    rd(A_SS);  chk("arst_status", read_data, 32'h0);

    for (int i = 0; i < 1600; i++) begin
      int sel;
      pd = (i < 800) ? 6 : 40;
      knn_done  = ($urandom_range(0, pd - 1) == 0);
      knn_class = ($urandom_range(0, 1) == 1);
      svm_done  = ($urandom_range(0, pd - 1) == 0);
      svm_class = ($urandom_range(0, 1) == 1);
      enable    = ($urandom_range(0, 2) == 0);
      write     = ($urandom_range(0, 1) == 1);
      write_data = $urandom;
      sel = $urandom_range(0, 5);
      case (sel)
        0: address = A_TH;
        1: address = A_OP;
        2, 3: address = A_ST;
        4: address = A_SS;
        default: address = bad_addr[$urandom_range(0, 3)];
      endcase
      cycle();
    end
    enable = 1'b0; write = 1'b0; knn_done = 1'b0; svm_done = 1'b0;
    repeat (TO + 4) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
